// File: rtl/gamepad_pmod_tx.sv
// ---------------------------------------------------------------------------
// gamepad_pmod_tx : serialises two 12-bit gamepad states onto the PMOD
//                   latch/clk/data link, optionally repeating frames.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gamepad_pmod_tx #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned AUTO    = 0,
    parameter int unsigned GAP     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] buttons1,
    input  logic [11:0] buttons2,
    input  logic        present1,
    input  logic        present2,
    output logic        busy,
    output logic        done,
    output logic        pmod_latch,
    output logic        pmod_clk,
    output logic        pmod_data
);

    localparam int unsigned HW = $clog2(2 * CLK_DIV + 1);
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [HW-1:0] HALF_LAST  = HW'(CLK_DIV - 1);
    localparam logic [HW-1:0] LATCH_LAST = HW'(2 * CLK_DIV - 1);
    localparam logic [HW-1:0] HALF_ONE   = HW'(1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP - 1);
    localparam logic [GW-1:0] GAP_ONE    = GW'(1);
    localparam logic [4:0]    LAST_BIT   = 5'd23;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LATCH    = 3'd3,
        DONE     = 3'd4,
        GAP_WAIT = 3'd5
    } state_t;

    state_t       state;
    state_t       state_next;
    logic         accept;
    logic         shift_step;
    logic         timed_state;
    logic [HW-1:0] half_cnt;
    logic [4:0]    bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic [23:0]   shreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        shift_step  = 1'b0;
        timed_state = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        pmod_latch  = 1'b0;
        pmod_clk    = 1'b0;
        pmod_data   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT_LO;
                    accept     = 1'b1;
                end
            end
            SHIFT_LO: begin
                timed_state = 1'b1;
                busy        = 1'b1;
                pmod_data   = shreg[23];
                if (half_cnt == HALF_LAST) begin
                    state_next = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                timed_state = 1'b1;
                busy        = 1'b1;
                pmod_clk    = 1'b1;
                pmod_data   = shreg[23];
                if (half_cnt == HALF_LAST) begin
                    shift_step = 1'b1;
                    state_next = (bit_cnt == LAST_BIT) ? LATCH : SHIFT_LO;
                end
            end
            LATCH: begin
                timed_state = 1'b1;
                busy        = 1'b1;
                pmod_latch  = 1'b1;
                if (half_cnt == LATCH_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = (AUTO != 0) ? GAP_WAIT : IDLE;
            end
            GAP_WAIT: begin
                // external start is deliberately not looked at here
                if (gap_cnt == GAP_LAST) begin
                    state_next = SHIFT_LO;
                    accept     = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counters restart on every state change, so they never need to wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            half_cnt <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            shreg    <= '0;
        end else begin
            if (timed_state && (state_next == state)) begin
                half_cnt <= half_cnt + HALF_ONE;
            end else begin
                half_cnt <= '0;
            end

            if ((state == GAP_WAIT) && (state_next == GAP_WAIT)) begin
                gap_cnt <= gap_cnt + GAP_ONE;
            end else begin
                gap_cnt <= '0;
            end

            if (accept) begin
                shreg   <= {present1 ? buttons1 : 12'hFFF,
                            present2 ? buttons2 : 12'hFFF};
                bit_cnt <= '0;
            end else if (shift_step) begin
                shreg   <= {shreg[22:0], 1'b0};
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gamepad_pmod_tx.sv
// ---------------------------------------------------------------------------
// tb_gamepad_pmod_tx : receiver-side model checking frame content and timing.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gamepad_pmod_tx;

    localparam int CD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, present1, present2;
    logic [11:0] buttons1, buttons2;
    logic        busy, done, pmod_latch, pmod_clk, pmod_data;

    logic        rst_n_a, start_a, present1_a, present2_a;
    logic [11:0] buttons1_a, buttons2_a;
    logic        busy_a, done_a, pmod_latch_a, pmod_clk_a, pmod_data_a;

    gamepad_pmod_tx #(.CLK_DIV(CD), .AUTO(0), .GAP(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .buttons1(buttons1), .buttons2(buttons2),
        .present1(present1), .present2(present2),
        .busy(busy), .done(done), .pmod_latch(pmod_latch),
        .pmod_clk(pmod_clk), .pmod_data(pmod_data)
    );

    gamepad_pmod_tx #(.CLK_DIV(1), .AUTO(1), .GAP(16)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a),
        .buttons1(buttons1_a), .buttons2(buttons2_a),
        .present1(present1_a), .present2(present2_a),
        .busy(busy_a), .done(done_a), .pmod_latch(pmod_latch_a),
        .pmod_clk(pmod_clk_a), .pmod_data(pmod_data_a)
    );

    typedef struct {
        logic [11:0] b1;
        logic [11:0] b2;
        logic        p1;
        logic        p2;
        logic [23:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] ref_word(input logic [11:0] b1, input logic [11:0] b2,
                                             input logic p1, input logic p2);
        return {p1 ? b1 : 12'hFFF, p2 ? b2 : 12'hFFF};
    endfunction

    task automatic run_frame(input vec_t v, input bit disturb, input bit start_in_done);
        logic [23:0] got;
        logic        prev_clk;
        int rises, latch_cyc, done_at, busy_bad, overlap, k;
        got = '0; rises = 0; latch_cyc = 0; done_at = 0; busy_bad = 0; overlap = 0;
        buttons1 = v.b1; buttons2 = v.b2; present1 = v.p1; present2 = v.p2;
        start = 1'b1;
        tick();
        prev_clk = 1'b0;
        k = 1;
        while (k <= 1000) begin
            start = 1'b0;
            if (k == 1) check("first_bit", {31'd0, pmod_data}, {31'd0, v.exp[23]});
            if (pmod_clk && !prev_clk) begin
                got = {got[22:0], pmod_data};
                rises++;
                if (disturb && rises == 10) begin
                    buttons1 = ~buttons1;
                    start    = 1'b1;
                end
            end
            prev_clk = pmod_clk;
            if (pmod_latch) latch_cyc++;
            if (pmod_latch && pmod_clk) overlap++;
            if (busy !== (k <= 50 * CD)) busy_bad++;
            if (done) begin
                done_at = k;
                break;
            end
            tick();
            k++;
        end
        check("frame_word", {8'd0, got}, {8'd0, v.exp});
        check("rise_count", rises, 24);
        check("latch_cycles", latch_cyc, 2 * CD);
        check("done_latency", done_at, 50 * CD + 1);
        check("busy_profile", busy_bad, 0);
        check("latch_clk_overlap", overlap, 0);
        if (start_in_done) start = 1'b1;
        tick();
        start = 1'b0;
        if (start_in_done) check("start_in_done_ignored", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        int cnt, busy_cnt, rises_a, ndone, k;
        int done_t[4];
        logic [23:0] got_a, exp_a;
        logic prev_a;
        logic found;

        vecs.push_back('{12'h801, 12'h000, 1'b1, 1'b1, 24'h801000});
        vecs.push_back('{12'h801, 12'h123, 1'b1, 1'b0, 24'h801FFF});
        vecs.push_back('{12'hABC, 12'h555, 1'b0, 1'b1, 24'hFFF555});
        vecs.push_back('{12'h000, 12'hFFF, 1'b1, 1'b1, 24'h000FFF});
        for (int i = 0; i < 4; i++) begin
            v.b1  = 12'($urandom);
            v.b2  = 12'($urandom);
            v.p1  = 1'($urandom_range(0, 1));
            v.p2  = 1'($urandom_range(0, 1));
            v.exp = ref_word(v.b1, v.b2, v.p1, v.p2);
            vecs.push_back(v);
        end

        rst_n = 1'b0; start = 1'b0; present1 = 1'b1; present2 = 1'b1;
        buttons1 = '0; buttons2 = '0;
        rst_n_a = 1'b0; start_a = 1'b0; present1_a = 1'b1; present2_a = 1'b1;
        buttons1_a = '0; buttons2_a = '0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outputs", {27'd0, busy, done, pmod_latch, pmod_clk, pmod_data}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("idle_outputs", {27'd0, busy, done, pmod_latch, pmod_clk, pmod_data}, 32'd0);

        foreach (vecs[i]) run_frame(vecs[i], 1'b0, (i == 1));

        // Mid-frame input change and start must neither alter nor queue a frame
        run_frame(vecs[0], 1'b1, 1'b0);
        cnt = 0;
        for (int i = 0; i < 250; i++) begin
            if (busy || done) cnt++;
            tick();
        end
        check("no_second_frame", cnt, 0);

        // Reset while latching aborts cleanly
        buttons1 = 12'h801; buttons2 = 12'h000; present1 = 1'b1; present2 = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (pmod_latch) found = 1'b1;
            else tick();
        end
        check("latch_reached", {31'd0, found}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("abort_outputs", {27'd0, busy, done, pmod_latch, pmod_clk, pmod_data}, 32'd0);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy || done) cnt++;
            tick();
        end
        check("abort_no_done", cnt, 0);
        run_frame(vecs[2], 1'b0, 1'b0);

        // AUTO instance: back-to-back frames, start held high throughout
        rst_n_a = 1'b1;
        tick();
        buttons1_a = 12'($urandom); buttons2_a = 12'($urandom);
        present1_a = 1'b1; present2_a = 1'($urandom_range(0, 1));
        exp_a = ref_word(buttons1_a, buttons2_a, present1_a, present2_a);
        start_a = 1'b1;
        tick();
        got_a = '0; rises_a = 0; busy_cnt = 0; ndone = 0; prev_a = 1'b0;
        k = 1;
        while (k <= 400 && ndone < 4) begin
            if (pmod_clk_a && !prev_a) begin
                got_a = {got_a[22:0], pmod_data_a};
                rises_a++;
            end
            prev_a = pmod_clk_a;
            if (busy_a) busy_cnt++;
            if (done_a) begin
                done_t[ndone] = k;
                check("auto_word", {8'd0, got_a}, {8'd0, exp_a});
                check("auto_rises", rises_a, 24);
                check("auto_busy_len", busy_cnt, 50);
                ndone++;
                buttons1_a = 12'($urandom); buttons2_a = 12'($urandom);
                present1_a = 1'($urandom_range(0, 1)); present2_a = 1'($urandom_range(0, 1));
                exp_a = ref_word(buttons1_a, buttons2_a, present1_a, present2_a);
                got_a = '0; rises_a = 0; busy_cnt = 0;
            end
            tick();
            k++;
        end
        start_a = 1'b0;
        check("auto_done_count", ndone, 4);
        for (int i = 0; i < ndone; i++) check("auto_done_time", done_t[i], 51 + 67 * i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
